// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache miss controller.
//   - state_t : controller states (IDLE, WB, FILL, INSTALL)
//   - INDEX_W / TAG_W : split of the 14-bit line address into tag and set index
//   - WORD_W / LINE_W : CPU word and cache line widths (four words per line)
package cache_ctrl_pkg;

  localparam int INDEX_W = 5;
  localparam int TAG_W   = 9;
  localparam int WORD_W  = 16;
  localparam int LINE_W  = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WB      = 2'd1,
    FILL    = 2'd2,
    INSTALL = 2'd3
  } state_t;

endpackage

// File: rtl/line_word_merge.sv
// Combinational word select / word merge on a cache line.
//   line     : source line
//   offset   : word offset within the line
//   word     : word to insert at offset
//   merged   : line with word [offset] replaced by word
//   selected : word [offset] of the source line
module line_word_merge #(
  parameter int WORD_W = 16,
  parameter int LINE_W = 64
) (
  input  logic [LINE_W-1:0] line,
  input  logic [1:0]        offset,
  input  logic [WORD_W-1:0] word,
  output logic [LINE_W-1:0] merged,
  output logic [WORD_W-1:0] selected
);

  localparam int WORDS = LINE_W / WORD_W;

  always_comb begin
    merged   = line;
    selected = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (offset == i[1:0]) begin
        merged[i*WORD_W +: WORD_W] = word;
        selected                   = line[i*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Blocking cache miss controller: services CPU reads/writes against an
// external cache array, writes back a dirty victim, fills the line from
// memory, installs it, and lets the CPU retry the access as a hit.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   cpu_re/we/addr/wdata       : CPU request (re+we together = write)
//   cpu_rdata, cpu_stall       : CPU read word, hold-request indication
//   c_*                        : cache array lookup / write interface
//   m_*                        : memory line interface, m_rdy = completion pulse
//   hit_cnt, miss_cnt          : saturating performance counters
//   dbg_state                  : current controller state
// Handshake: the CPU holds its request while cpu_stall=1; memory holds the
// request strobe (m_re or m_we) high until a single-cycle m_rdy completes it.
module cache_miss_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int LINE_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_re,
  input  logic                     cpu_we,
  input  logic [15:0]              cpu_addr,
  input  logic [WORD_W-1:0]        cpu_wdata,
  output logic [WORD_W-1:0]        cpu_rdata,
  output logic                     cpu_stall,
  output logic [TAG_W+INDEX_W-1:0] c_addr,
  output logic                     c_re,
  output logic                     c_we,
  output logic [LINE_W-1:0]        c_wr_data,
  output logic                     c_wdirty,
  output logic                     c_toggle,
  input  logic [LINE_W-1:0]        c_rd_data,
  input  logic [TAG_W-1:0]         c_tag_out,
  input  logic                     c_hit,
  input  logic                     c_dirty,
  output logic [TAG_W+INDEX_W-1:0] m_addr,
  output logic                     m_re,
  output logic                     m_we,
  output logic [LINE_W-1:0]        m_wdata,
  input  logic [LINE_W-1:0]        m_rdata,
  input  logic                     m_rdy,
  output logic [CNT_W-1:0]         hit_cnt,
  output logic [CNT_W-1:0]         miss_cnt,
  output state_t                   dbg_state
);

  state_t              state_q, state_d;
  logic                req, hit, miss;
  logic [15:0]         addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic                wr_q;
  logic [TAG_W-1:0]    tag_q;
  logic [LINE_W-1:0]   victim_q, fill_q;
  // Set by INSTALL so the following retried access is not counted as a hit.
  logic                retry_q;
  logic [LINE_W-1:0]   hit_line, inst_line;
  logic [WORD_W-1:0]   hit_word, inst_word;

  assign req       = cpu_re | cpu_we;
  assign hit       = (state_q == IDLE) & req & c_hit;
  assign miss      = (state_q == IDLE) & req & ~c_hit;
  assign dbg_state = state_q;

  // Hit path: merge into / select from the line the cache is presenting now.
  line_word_merge #(.WORD_W(WORD_W), .LINE_W(LINE_W)) u_hit_merge (
    .line     (c_rd_data),
    .offset   (cpu_addr[1:0]),
    .word     (cpu_wdata),
    .merged   (hit_line),
    .selected (hit_word)
  );

  // Install path: merge the latched write word into the fetched line.
  line_word_merge #(.WORD_W(WORD_W), .LINE_W(LINE_W)) u_inst_merge (
    .line     (fill_q),
    .offset   (addr_q[1:0]),
    .word     (wdata_q),
    .merged   (inst_line),
    .selected (inst_word)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; m_rdy is only meaningful in WB and FILL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss) state_d = c_dirty ? WB : FILL;
      WB:      if (m_rdy) state_d = FILL;
      FILL:    if (m_rdy) state_d = INSTALL;
      INSTALL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; everything is forced quiet while reset is asserted so a reset
  // in the middle of WB/FILL drops the memory request at once.
  always_comb begin
    c_re      = 1'b0;
    c_we      = 1'b0;
    c_addr    = cpu_addr[15:2];
    c_wr_data = hit_line;
    c_wdirty  = 1'b0;
    c_toggle  = 1'b0;
    m_re      = 1'b0;
    m_we      = 1'b0;
    m_addr    = addr_q[15:2];
    m_wdata   = victim_q;
    cpu_stall = 1'b0;
    cpu_rdata = hit_word;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          c_re      = req;
          c_we      = hit & cpu_we;
          c_wdirty  = hit & cpu_we;
          cpu_stall = miss;
        end
        WB: begin
          m_we      = 1'b1;
          m_addr    = {tag_q, addr_q[INDEX_W+1:2]};
          cpu_stall = 1'b1;
        end
        FILL: begin
          m_re      = 1'b1;
          cpu_stall = 1'b1;
        end
        INSTALL: begin
          c_we      = 1'b1;
          c_toggle  = 1'b1;
          c_addr    = addr_q[15:2];
          c_wr_data = wr_q ? inst_line : fill_q;
          c_wdirty  = wr_q;
          cpu_stall = 1'b1;
          cpu_rdata = inst_word;
        end
        default: ;
      endcase
    end
  end

  // Miss context, fill data and retry marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      tag_q    <= '0;
      victim_q <= '0;
      fill_q   <= '0;
      retry_q  <= 1'b0;
    end else begin
      if (miss) begin
        addr_q   <= cpu_addr;
        wdata_q  <= cpu_wdata;
        wr_q     <= cpu_we;
        tag_q    <= c_tag_out;
        victim_q <= c_rd_data;
      end
      if (state_q == FILL && m_rdy) fill_q <= m_rdata;
      if (state_q == INSTALL)             retry_q <= 1'b1;
      else if (state_q == IDLE && req)    retry_q <= 1'b0;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit && !retry_q && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      if (miss && miss_cnt != '1)           miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
module tb_cache_miss_ctrl;
  import cache_ctrl_pkg::*;

  localparam int EW = 82;  // {kind[1:0], addr[13:0], data[63:0], dirty, toggle}
  typedef logic [EW-1:0] ev_t;
  localparam logic [1:0] K_CWR = 2'd0, K_MWR = 2'd1, K_MRD = 2'd2;

  logic        clk, rst_n;
  logic        cpu_re, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic [13:0] c_addr, m_addr;
  logic        c_re, c_we, c_wdirty, c_toggle;
  logic [63:0] c_wr_data, c_rd_data, m_wdata, m_rdata;
  logic [8:0]  c_tag_out;
  logic        c_hit, c_dirty;
  logic        m_re, m_we, m_rdy;
  logic [15:0] hit_cnt, miss_cnt;
  state_t      dbg_state;

  cache_miss_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .c_addr(c_addr), .c_re(c_re), .c_we(c_we), .c_wr_data(c_wr_data),
    .c_wdirty(c_wdirty), .c_toggle(c_toggle), .c_rd_data(c_rd_data),
    .c_tag_out(c_tag_out), .c_hit(c_hit), .c_dirty(c_dirty),
    .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_rdy(m_rdy),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int overlap_cnt = 0;

  function automatic void check(string name, logic [EW-1:0] act, logic [EW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic ev_t mk_ev(logic [1:0] k, logic [13:0] a, logic [63:0] d,
                                logic dirty, logic tog);
    return {k, a, d, dirty, tog};
  endfunction

  // ---------------- memory responder ----------------
  int mem_lat = 1;
  int mem_cnt = 0;
  logic stray_rdy = 1'b0;

  initial begin
    m_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (m_rdy) mem_cnt = 0;
      if (m_re || m_we) begin
        mem_cnt++;
        m_rdy = (mem_cnt == mem_lat) || stray_rdy;
      end else begin
        mem_cnt = 0;
        m_rdy = stray_rdy;
      end
    end
  end

  // ---------------- monitor ----------------
  logic prev_m_re = 1'b0, prev_m_we = 1'b0;

  task automatic pop_cmp(string name, ev_t act);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: unexpected event %h, expected none", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if ((m_re && m_we) || (c_we && (m_re || m_we))) overlap_cnt++;
      if (c_we) pop_cmp("ev_cache_wr", mk_ev(K_CWR, c_addr, c_wr_data, c_wdirty, c_toggle));
      if (m_we && !prev_m_we) pop_cmp("ev_mem_wr", mk_ev(K_MWR, m_addr, m_wdata, 1'b0, 1'b0));
      if (m_re && !prev_m_re) pop_cmp("ev_mem_rd", mk_ev(K_MRD, m_addr, 64'h0, 1'b0, 1'b0));
      prev_m_re = m_re;
      prev_m_we = m_we;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_re = 1'b0; cpu_we = 1'b0; c_hit = 1'b0; c_dirty = 1'b0;
  endtask

  // Issue a missing access and follow it through to the retried hit.
  // Returns at the posedge+1 after the retry cycle with the request dropped.
  task automatic do_miss(input string tag_name, input logic [15:0] addr,
                         input logic re, input logic we, input logic [15:0] wdata,
                         input logic dirty, input logic [8:0] tag, input logic [13:0] wb_addr,
                         input logic [63:0] victim, input logic [63:0] fill,
                         input logic [63:0] line, input int lat,
                         input int exp_stalls, input logic [15:0] exp_rdata);
    int stalls;
    logic done, inst;
    mem_lat = lat; m_rdata = fill;
    cpu_re = re; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    c_hit = 1'b0; c_dirty = dirty; c_tag_out = tag; c_rd_data = victim;
    if (dirty) exp_q.push_back(mk_ev(K_MWR, wb_addr, victim, 1'b0, 1'b0));
    exp_q.push_back(mk_ev(K_MRD, addr[15:2], 64'h0, 1'b0, 1'b0));
    exp_q.push_back(mk_ev(K_CWR, addr[15:2], line, we, 1'b1));
    if (we) exp_q.push_back(mk_ev(K_CWR, addr[15:2], line, 1'b1, 1'b0));
    stalls = 0; done = 1'b0; inst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!cpu_stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      if (c_we) inst = 1'b1;
      next_cycle();
      if (inst) begin
        c_hit = 1'b1; c_dirty = 1'b0; c_rd_data = line;
      end
    end
    check({tag_name, "_done"}, EW'(done), EW'(1'b1));
    check({tag_name, "_stalls"}, EW'(stalls), EW'(exp_stalls));
    check({tag_name, "_rdata"}, EW'(cpu_rdata), EW'(exp_rdata));
    next_cycle();
    idle_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; stray_rdy = 1'b0;
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040; cpu_wdata = 16'h0;
    c_rd_data = 64'h0; c_tag_out = 9'h0; c_hit = 1'b0; c_dirty = 1'b0; m_rdata = 64'h0;

    // reset: request held but everything must stay quiet
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", EW'(cpu_stall), EW'(0));
    check("rst_c_re", EW'(c_re), EW'(0));
    check("rst_hit_cnt", EW'(hit_cnt), EW'(0));
    check("rst_miss_cnt", EW'(miss_cnt), EW'(0));
    next_cycle();
    idle_inputs();
    rst_n = 1'b1;

    // idle with no request
    @(negedge clk);
    check("idle_strobes", EW'({c_re, c_we, m_re, m_we, c_toggle}), EW'(0));
    check("idle_stall", EW'(cpu_stall), EW'(0));
    next_cycle();

    // stray m_rdy in IDLE is ignored
    stray_rdy = 1'b1;
    next_cycle();
    stray_rdy = 1'b0;
    next_cycle();
    @(negedge clk);
    check("stray_state", EW'(dbg_state), EW'(IDLE));
    check("stray_quiet", EW'({cpu_stall, m_re, m_we, c_we}), EW'(0));
    next_cycle();

    // cold read miss at 0x0040, latency 3: 5 stall cycles, m_addr 0x0010
    do_miss("rd_cold", 16'h0040, 1'b1, 1'b0, 16'h0, 1'b0, 9'h0, 14'h0,
            64'h0, 64'h4444_3333_2222_1111, 64'h4444_3333_2222_1111, 3, 5, 16'h1111);
    @(negedge clk);
    check("rd_cold_miss_cnt", EW'(miss_cnt), EW'(1));
    check("rd_cold_hit_cnt", EW'(hit_cnt), EW'(0));
    next_cycle();

    // write hit 0xBEEF at 0x0042
    cpu_we = 1'b1; cpu_addr = 16'h0042; cpu_wdata = 16'hBEEF;
    c_hit = 1'b1; c_rd_data = 64'h4444_3333_2222_1111;
    exp_q.push_back(mk_ev(K_CWR, 14'h0010, 64'h4444_BEEF_2222_1111, 1'b1, 1'b0));
    @(negedge clk);
    check("wr_hit_stall", EW'(cpu_stall), EW'(0));
    next_cycle();
    // read hit 0x0043 on the updated line
    cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 16'h0043;
    c_rd_data = 64'h4444_BEEF_2222_1111;
    @(negedge clk);
    check("wr_hit_cnt", EW'(hit_cnt), EW'(1));
    check("rd_hit_rdata", EW'(cpu_rdata), EW'(16'h4444));
    check("rd_hit_stall", EW'(cpu_stall), EW'(0));
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("rd_hit_cnt", EW'(hit_cnt), EW'(2));
    next_cycle();

    // dirty miss at 0x1234: WB to {0x1A5, 0x0D} = 0x34AD, then fill 0x048D
    do_miss("dirty", 16'h1234, 1'b1, 1'b0, 16'h0, 1'b1, 9'h1A5, 14'h34AD,
            64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF,
            64'h0123_4567_89AB_CDEF, 2, 6, 16'hCDEF);
    @(negedge clk);
    check("dirty_miss_cnt", EW'(miss_cnt), EW'(2));
    next_cycle();

    // re+we together on a miss at 0x0101: treated as a write, merged install
    do_miss("rdwr", 16'h0101, 1'b1, 1'b1, 16'h5A5A, 1'b0, 9'h0, 14'h0,
            64'h0, 64'h8888_7777_6666_5555, 64'h8888_7777_5A5A_5555, 1, 3, 16'h5A5A);
    @(negedge clk);
    check("rdwr_miss_cnt", EW'(miss_cnt), EW'(3));
    check("rdwr_hit_cnt", EW'(hit_cnt), EW'(2));
    next_cycle();

    // reset in the middle of FILL
    mem_lat = 10;
    cpu_re = 1'b1; cpu_addr = 16'h0800; c_hit = 1'b0; c_dirty = 1'b0;
    exp_q.push_back(mk_ev(K_MRD, 14'h0200, 64'h0, 1'b0, 1'b0));
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("midfill_m_re", EW'(m_re), EW'(1));
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    check("midfill_rst_quiet", EW'({m_re, m_we, c_we, c_re}), EW'(0));
    check("midfill_rst_stall", EW'(cpu_stall), EW'(0));
    check("midfill_rst_state", EW'(dbg_state), EW'(IDLE));
    next_cycle();
    idle_inputs();
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("midfill_cnts", EW'({hit_cnt, miss_cnt}), EW'(0));
    next_cycle();

    // hit counter saturation
    cpu_re = 1'b1; cpu_addr = 16'h0040; c_hit = 1'b1; c_rd_data = 64'h4444_3333_2222_1111;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_fffe", EW'(hit_cnt), EW'(16'hFFFE));
    next_cycle();
    check("sat_ffff", EW'(hit_cnt), EW'(16'hFFFF));
    repeat (3) @(posedge clk);
    #1;
    check("sat_hold", EW'(hit_cnt), EW'(16'hFFFF));
    idle_inputs();

    repeat (3) next_cycle();
    check("sb_empty", EW'(exp_q.size()), EW'(0));
    check("no_overlap", EW'(overlap_cnt), EW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_miss_ctrl.md
CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

Interface
REQ-001 Parameter, one per line: name, default, meaning.
- WORD_W, 16, CPU word width.
- LINE_W, 64, cache line width (4 words).
- CNT_W, 16, width of each performance counter.
REQ-002 Ports, one per line: name  direction  width  meaning.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_re  in  1  CPU read request.
- cpu_we  in  1  CPU write request.
- cpu_addr  in  16  CPU word address; [15:2] is the line address, [1:0] is the word offset.
- cpu_wdata  in  16  CPU write word.
- cpu_rdata  out  16  CPU read word.
- cpu_stall  out  1  CPU must hold its request.
- c_addr  out  14  cache line address.
- c_re / c_we  out  1 each  cache read / write strobe.
- c_wr_data  out  64  cache write line.
- c_wdirty  out  1  dirty bit to store with the written line.
- c_toggle  out  1  flip LRU on this write.
- c_rd_data  in  64  cache read line.
- c_tag_out  in  9  victim tag.
- c_hit / c_dirty  in  1 each  cache hit / victim dirty.
- m_addr  out  14  memory line address.
- m_re / m_we  out  1 each  memory read / write request.
- m_wdata  out  64  memory write line.
- m_rdata  in  64  memory read line.
- m_rdy  in  1  one-cycle pulse when the memory transaction completes.
- hit_cnt / miss_cnt  out  CNT_W each  performance counters.

Function
REQ-003 The state machine SHALL have four states: IDLE, WB, FILL, INSTALL.
REQ-004 In IDLE, with cpu_re or cpu_we asserted, the block SHALL drive c_re=1 and c_addr=cpu_addr[15:2], and SHALL sample c_hit in the same cycle.
REQ-005 On a read hit, the block SHALL:
- drive cpu_rdata = c_rd_data word [cpu_addr[1:0]], combinationally;
- hold cpu_stall=0;
- increment hit_cnt.
REQ-006 On a write hit, the block SHALL:
- drive c_we=1, c_wdirty=1, c_toggle=0;
- drive c_wr_data = c_rd_data with word [cpu_addr[1:0]] replaced by cpu_wdata;
- hold cpu_stall=0;
- increment hit_cnt.
REQ-007 On a miss, the block SHALL:
- assert cpu_stall in the same cycle;
- latch cpu_addr, cpu_wdata, the request type, c_tag_out and c_rd_data;
- increment miss_cnt;
- go to WB if c_dirty=1, otherwise go to FILL.
REQ-008 WB SHALL hold m_we=1, m_addr={latched tag, latched index}, m_wdata=latched victim line until m_rdy, then go to FILL.
REQ-009 FILL SHALL hold m_re=1, m_addr=latched line address until m_rdy, and SHALL capture m_rdata on that edge, then go to INSTALL.
REQ-010 INSTALL SHALL last exactly one cycle and SHALL drive c_we=1, c_toggle=1 and c_addr=latched line address, then go to IDLE:
- read miss: c_wr_data=fill line, c_wdirty=0;
- write miss: latched word merged into the fill line, c_wdirty=1.
REQ-011 cpu_stall SHALL be 1 in WB, FILL and INSTALL; the retried access in IDLE then hits, so the miss penalty is 2 + memory latency cycles (plus the WB latency when the victim is dirty).
REQ-012 With cpu_re and cpu_we both asserted, the request SHALL be treated as a write.
REQ-013 m_re and m_we SHALL never be asserted together; c_we SHALL never be asserted in WB or FILL.
REQ-014 An m_rdy pulse in IDLE or INSTALL SHALL be ignored.
REQ-015 Counters SHALL saturate at all-ones and SHALL NOT wrap; the retry hit after a miss SHALL NOT increment hit_cnt.
REQ-016 With no request in IDLE, all strobes SHALL be 0 and cpu_stall SHALL be 0.

Reset
REQ-017 While rst_n=0, regardless of state, the block SHALL:
- enter IDLE;
- clear hit_cnt, miss_cnt and all latched registers;
- drive every strobe, cpu_stall and c_toggle to 0.
REQ-018 Reset asserted mid-WB or mid-FILL SHALL abandon the transaction immediately with no cache write.

Structure
REQ-019 Package cache_ctrl_pkg SHALL hold the state enum and the constants INDEX_W=5, TAG_W=9, WORD_W, LINE_W.
REQ-020 Word merge and word select SHALL live in one combinational sub-module, line_word_merge, which is instantiated for both the hit-write path and the install path.

Verification
REQ-021 Read 0x0040 to a cold cache, memory latency 3 cycles -> stall for 5 cycles; m_addr=0x0010; INSTALL with c_wdirty=0; then hit; miss_cnt=1, hit_cnt=0.
REQ-022 Write 0xBEEF to 0x0042 on a hit -> c_we=1, c_wdirty=1, word 2 of the line = 0xBEEF, no stall, hit_cnt+1.
REQ-023 Miss where c_dirty=1 and c_tag_out=0x1A5 -> WB with m_addr={0x1A5, index}, then FILL; no overlap of m_re and m_we.
REQ-024 Assert rst_n=0 mid-FILL -> IDLE, m_re=0, cpu_stall=0, no c_we pulse.
REQ-025 Preload hit_cnt to 0xFFFF, then issue one more hit -> hit_cnt stays 0xFFFF.
REQ-026 Assert cpu_re and cpu_we together on a miss -> the install carries c_wdirty=1 with the merged word.
